// File: rtl/axi_pkg.sv
// AXI response encodings shared by the handshake-to-AXI bridge and the slave-side converter.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/hs_2_axi.sv
// Single-outstanding request/ready handshake master to AXI4-Lite master bridge.
// state   | meaning
// IDLE    | waiting for hs_read_i / hs_write_i, request latched on exit
// RD_ADDR | arvalid_o high until AR handshake
// RD_DATA | rready_o high until R beat, data and error captured
// WR_REQ  | awvalid_o / wvalid_o, each dropped after its own handshake
// WR_RESP | bready_o high until B beat, error captured
// DONE    | one-cycle hs_ready_o pulse
module hs_2_axi
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                hs_read_i,
  input  logic                hs_write_i,
  input  logic [ADDR_W-1:0]   hs_addr_i,
  input  logic [DATA_W-1:0]   hs_data_i,
  input  logic [DATA_W/8-1:0] hs_byte_select_i,
  output logic                hs_ready_o,
  output logic [DATA_W-1:0]   hs_data_o,
  output logic                hs_error_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  aw_hs;
  logic                  w_hs;

  assign arvalid_o  = (state_q == RD_ADDR);
  assign rready_o   = (state_q == RD_DATA);
  assign awvalid_o  = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid_o   = (state_q == WR_REQ) && !w_done_q;
  assign bready_o   = (state_q == WR_RESP);
  assign hs_ready_o = (state_q == DONE);
  assign hs_error_o = (state_q == DONE) && err_q;
  assign hs_data_o  = rdata_q;
  assign araddr_o   = addr_q;
  assign awaddr_o   = addr_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = strb_q;

  assign aw_hs = awvalid_o && awready_i;
  assign w_hs  = wvalid_o && wready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // write has priority; a simultaneous read is dropped
        if (hs_write_i)     state_d = WR_REQ;
        else if (hs_read_i) state_d = RD_ADDR;
      end
      RD_ADDR: if (arready_i) state_d = RD_DATA;
      RD_DATA: if (rvalid_i)  state_d = DONE;
      WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: if (bvalid_i)  state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (hs_write_i || hs_read_i) begin
            addr_q    <= hs_addr_i & WORD_MASK;
            wdata_q   <= hs_data_i;
            strb_q    <= hs_byte_select_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rdata_q <= rdata_i;
            err_q   <= (rresp_i != AXI_RESP_OKAY);
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        WR_RESP: begin
          if (bvalid_i) err_q <= (bresp_i != AXI_RESP_OKAY);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_2_axi.sv
// Bench for hs_2_axi: requester plus AXI-Lite slave with programmable wait states,
// checked each cycle against a transaction-level model of channel order and latency.
module tb_hs_2_axi;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        hs_read_i = 1'b0, hs_write_i = 1'b0;
  logic [31:0] hs_addr_i = '0, hs_data_i = '0;
  logic [3:0]  hs_byte_select_i = '0;
  logic        hs_ready_o, hs_error_o;
  logic [31:0] hs_data_o;
  logic        arvalid_o, arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic        rvalid_i = 1'b0, rready_o;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        awvalid_o, awready_i = 1'b0;
  logic [31:0] awaddr_o;
  logic        wvalid_o, wready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i = 1'b0, bready_o;
  logic [1:0]  bresp_i = '0;

  always #5 clk_i = ~clk_i;

  hs_2_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hs_read_i(hs_read_i), .hs_write_i(hs_write_i), .hs_addr_i(hs_addr_i),
    .hs_data_i(hs_data_i), .hs_byte_select_i(hs_byte_select_i),
    .hs_ready_o(hs_ready_o), .hs_data_o(hs_data_o), .hs_error_o(hs_error_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_hsdata = '0;
  int          last_lat, last_ar_cyc;
  logic [31:0] last_data, last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_err;
  int          seen_ar;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid_o), 32'd0);
    chk({tag, "_rready"},  32'(rready_o),  32'd0);
    chk({tag, "_awvalid"}, 32'(awvalid_o), 32'd0);
    chk({tag, "_wvalid"},  32'(wvalid_o),  32'd0);
    chk({tag, "_bready"},  32'(bready_o),  32'd0);
    chk({tag, "_ready"},   32'(hs_ready_o), 32'd0);
    chk({tag, "_error"},   32'(hs_error_o), 32'd0);
    chk({tag, "_data"},    hs_data_o, model_hsdata);
  endtask

  // One request from issue to return-to-idle; slave waits are cycles of valid before ready.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input int ar_d, input int r_d, input int aw_d, input int w_d,
                         input int b_d, input logic [31:0] rdata, input logic [1:0] resp,
                         input logic scramble, input logic abort);
    logic        is_wr, exp_err, finished, armed;
    logic [31:0] eaddr;
    int          exp_lat, cyc, ar_c, r_c, aw_c, w_c, b_c, n_ready, ready_cyc;
    logic        ar_done, r_done, aw_done, w_done, b_done;
    logic        ar_p, r_p, aw_p, w_p, b_p;
    is_wr   = wr;
    eaddr   = addr & 32'hFFFF_FFFC;
    exp_err = (resp != 2'b00);
    exp_lat = is_wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
    cyc = 0; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; n_ready = 0; ready_cyc = -1;
    {ar_done, r_done, aw_done, w_done, b_done} = '0;
    {ar_p, r_p, aw_p, w_p, b_p} = '0;
    finished = 1'b0; armed = 1'b0; seen_ar = -1;
    hs_read_i = rd; hs_write_i = wr; hs_addr_i = addr; hs_data_i = data; hs_byte_select_i = strb;
    while (!finished && cyc < 200) begin
      @(posedge clk_i); #1; cyc++;
      if (ar_p) ar_done = 1'b1;
      if (aw_p) aw_done = 1'b1;
      if (w_p)  w_done  = 1'b1;
      if (b_p)  b_done  = 1'b1;
      if (r_p) begin r_done = 1'b1; model_hsdata = rdata; end
      if (armed) begin
        model_hsdata = '0;
        chk_quiet("abort");
        rst_ni = 1'b1; hs_read_i = 1'b0; hs_write_i = 1'b0;
        {arready_i, rvalid_i, awready_i, wready_i, bvalid_i} = '0;
        finished = 1'b1;
      end else begin
        if (scramble) begin
          hs_addr_i = $urandom; hs_data_i = $urandom; hs_byte_select_i = 4'($urandom);
        end
        chk("hs_data_hold", hs_data_o, model_hsdata);
        if (is_wr) begin
          chk("arvalid_wr", 32'(arvalid_o), 32'd0);
          chk("rready_wr",  32'(rready_o),  32'd0);
          chk("awvalid",    32'(awvalid_o), 32'(!aw_done));
          chk("wvalid",     32'(wvalid_o),  32'(!w_done));
          chk("bready",     32'(bready_o),  32'(aw_done && w_done && !b_done));
          if (awvalid_o) chk("awaddr", awaddr_o, eaddr);
          if (wvalid_o) begin
            chk("wdata", wdata_o, data);
            chk("wstrb", 32'(wstrb_o), 32'(strb));
          end
          if (awvalid_o) last_awaddr = awaddr_o;
          if (wvalid_o) begin last_wdata = wdata_o; last_wstrb = wstrb_o; end
        end else begin
          chk("awvalid_rd", 32'(awvalid_o), 32'd0);
          chk("wvalid_rd",  32'(wvalid_o),  32'd0);
          chk("bready_rd",  32'(bready_o),  32'd0);
          chk("arvalid",    32'(arvalid_o), 32'(!ar_done));
          chk("rready",     32'(rready_o),  32'(ar_done && !r_done));
          if (arvalid_o) begin
            chk("araddr", araddr_o, eaddr);
            last_araddr = araddr_o;
            if (seen_ar < 0) seen_ar = cyc;
          end
        end
        chk("hs_ready", 32'(hs_ready_o), 32'((is_wr ? b_done : r_done) && n_ready == 0));
        if (hs_ready_o) begin
          chk("hs_error", 32'(hs_error_o), 32'(exp_err));
          n_ready++;
          if (ready_cyc < 0) ready_cyc = cyc;
          last_data = hs_data_o; last_err = hs_error_o;
        end
        if (ready_cyc >= 0 && cyc == ready_cyc + 1) begin hs_read_i = 1'b0; hs_write_i = 1'b0; end
        if (ready_cyc >= 0 && cyc == ready_cyc + 2) finished = 1'b1;
        // slave side: decide inputs sampled at the coming edge
        if (arvalid_o) ar_c++;
        arready_i = arvalid_o && (ar_c > ar_d);
        ar_p = arvalid_o && arready_i;
        if (ar_done && !r_done) r_c++;
        rvalid_i = ar_done && !r_done && (r_c > r_d);
        rdata_i  = rvalid_i ? rdata : $urandom;
        rresp_i  = rvalid_i ? resp : 2'($urandom);
        r_p = rvalid_i && rready_o;
        if (awvalid_o) aw_c++;
        awready_i = awvalid_o && (aw_c > aw_d);
        aw_p = awvalid_o && awready_i;
        if (wvalid_o) w_c++;
        wready_i = wvalid_o && (w_c > w_d);
        w_p = wvalid_o && wready_i;
        if (aw_done && w_done && !b_done) b_c++;
        if (abort && bready_o) begin rst_ni = 1'b0; armed = 1'b1; end
        bvalid_i = aw_done && w_done && !b_done && (b_c > b_d) && !armed;
        bresp_i  = bvalid_i ? resp : 2'($urandom);
        b_p = bvalid_i && bready_o;
      end
    end
    {arready_i, rvalid_i, awready_i, wready_i, bvalid_i} = '0;
    if (!finished) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: no completion after %0d cycles, required within 200", cyc);
      hs_read_i = 1'b0; hs_write_i = 1'b0;
    end else if (!abort) begin
      chk("ready_count", 32'(n_ready), 32'd1);
      chk("latency", 32'(ready_cyc), 32'(exp_lat));
    end
    last_lat = ready_cyc; last_ar_cyc = seen_ar;
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_quiet("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // zero-wait read
    run_txn(1, 0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0);
    chk("lit_rd_lat",    32'(last_lat), 32'd3);
    chk("lit_rd_arcyc",  32'(last_ar_cyc), 32'd1);
    chk("lit_rd_araddr", last_araddr, 32'h0000_0104);
    chk("lit_rd_data",   last_data, 32'hDEAD_BEEF);
    chk("lit_rd_err",    32'(last_err), 32'd0);

    // W accepted three cycles before AW
    run_txn(0, 1, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 0, 3, 0, 0, 32'h0, 2'b00, 0, 0);
    chk("lit_wr_lat",    32'(last_lat), 32'd6);
    chk("lit_wr_awaddr", last_awaddr, 32'h0000_0010);
    chk("lit_wr_wdata",  last_wdata, 32'hA5A5_A5A5);
    chk("lit_wr_wstrb",  32'(last_wstrb), 32'h3);
    chk("lit_wr_keep",   last_data, 32'hDEAD_BEEF);

    // simultaneous read and write: write only
    run_txn(1, 1, 32'h0000_0022, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 0, 32'h1111_1111, 2'b00, 0, 0);
    chk("lit_both_lat",    32'(last_lat), 32'd3);
    chk("lit_both_awaddr", last_awaddr, 32'h0000_0020);

    // error responses
    run_txn(1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 2, 0, 0, 0, 32'hCAFE_0001, 2'b10, 0, 0);
    chk("lit_rerr", 32'(last_err), 32'd1);
    run_txn(0, 1, 32'h0000_0044, 32'h5555_AAAA, 4'b1000, 0, 0, 1, 2, 1, 32'h0, 2'b11, 0, 0);
    chk("lit_berr", 32'(last_err), 32'd1);

    // AR backpressure while the request inputs wander
    run_txn(1, 0, 32'h0000_0207, 32'h0, 4'h0, 5, 0, 0, 0, 0, 32'h7777_0000, 2'b00, 1, 0);
    chk("lit_bp_lat",    32'(last_lat), 32'd8);
    chk("lit_bp_araddr", last_araddr, 32'h0000_0204);

    // reset while waiting for B, then a clean read
    run_txn(0, 1, 32'h0000_0050, 32'h1234_0000, 4'hF, 0, 0, 0, 0, 10, 32'h0, 2'b00, 0, 1);
    run_txn(1, 0, 32'h0000_0030, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 0);
    chk("lit_post_rst_lat",  32'(last_lat), 32'd3);
    chk("lit_post_rst_data", last_data, 32'h1234_5678);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      run_txn(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), $urandom, 2'($urandom),
              1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
